spi_master: RTL and testbench

- Byte-oriented SPI master, mode 0 (CPOL=0, CPHA=0), MSB first, with software-controlled slave-select framing.
- Lets the FPGA initiate SPI transfers to on-board peripherals such as flash, DAC or a second FPGA, driving sck/ss/mosi itself.
- It is the initiator counterpart of the existing SPI slave logic on the AVR link. Slave-side sampling conventions (sample on sck rising, shift on sck falling) are matched exactly.

---
 rtl/spi_master_if.sv | 29 ++
 rtl/spi_master.sv | 151 +++++++++++++++
 tb/tb_spi_master.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_if
// Brief    : Request/response and SPI pin bundle between a host and spi_master.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_master_if;
   logic       start;
   logic [7:0] din;
   logic       last;
   logic       miso;
   logic       mosi;
   logic       sck;
   logic       ss;
   logic       busy;
   logic       done;
   logic [7:0] dout;

   modport master (
      input  start, din, last, miso,
      output mosi, sck, ss, busy, done, dout
   );

   modport slave (
      output start, din, last, miso,
      input  mosi, sck, ss, busy, done, dout
   );
endinterface
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_master
// Brief    : Byte-oriented SPI mode-0 master, MSB first, host-framed slave select.
// Revision : 1.0 - initial release
// ============================================================================
module spi_master #(
   parameter int CLK_DIV  = 4,
   parameter int SS_SETUP = 2
) (
   input  wire logic    clk,
   input  wire logic    rst,
   spi_master_if.master bus
);
   localparam int DIV_W = $clog2(CLK_DIV + 1);
   localparam int SS_W  = $clog2(SS_SETUP + 1);

   localparam logic [DIV_W-1:0] c_div_load = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] c_div_full = DIV_W'(CLK_DIV);
   localparam logic [DIV_W-1:0] c_div_one  = DIV_W'(1);
   localparam logic [SS_W-1:0]  c_ss_full  = SS_W'(SS_SETUP);
   localparam logic [SS_W-1:0]  c_ss_hold  = SS_W'(SS_SETUP - 1);
   localparam logic [SS_W-1:0]  c_ss_one   = SS_W'(1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_SETUP    = 3'd1,
      S_XFER     = 3'd2,
      S_WAIT     = 3'd3,
      S_TEARDOWN = 3'd4
   } state_t;

   state_t           r_state;
   logic [DIV_W-1:0] r_div_cnt;
   logic [SS_W-1:0]  r_ss_cnt;
   logic [3:0]       r_half;
   logic [7:0]       r_tx;
   logic [7:0]       r_rx;
   logic [7:0]       r_dout;
   logic             r_last;
   logic             r_sck;
   logic             r_ss;
   logic             r_mosi;
   logic             r_busy;
   logic             r_done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_div_cnt <= '0;
         r_ss_cnt  <= '0;
         r_half    <= '0;
         r_tx      <= '0;
         r_rx      <= '0;
         r_dout    <= '0;
         r_last    <= 1'b0;
         r_sck     <= 1'b0;
         r_ss      <= 1'b1;
         r_mosi    <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_tx     <= bus.din;
                  r_last   <= bus.last;
                  r_mosi   <= bus.din[7];
                  r_busy   <= 1'b1;
                  r_ss_cnt <= c_ss_full;
                  r_state  <= S_SETUP;
               end
            end

            // ss drops one cycle after acceptance, then SS_SETUP cycles before XFER.
            S_SETUP: begin
               r_ss <= 1'b0;
               if (r_ss_cnt == '0) begin
                  r_div_cnt <= c_div_load;
                  r_half    <= '0;
                  r_state   <= S_XFER;
               end else begin
                  r_ss_cnt <= r_ss_cnt - c_ss_one;
               end
            end

            S_XFER: begin
               if (r_div_cnt == '0) begin
                  r_div_cnt <= c_div_load;
                  r_sck     <= ~r_sck;
                  r_half    <= r_half + 4'd1;
                  if (!r_sck) begin
                     r_rx <= {r_rx[6:0], bus.miso};
                  end else if (r_half == 4'd15) begin
                     r_done <= 1'b1;
                     r_dout <= r_rx;
                     if (r_last) begin
                        r_ss_cnt <= c_ss_hold;
                        r_state  <= S_TEARDOWN;
                     end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_WAIT;
                     end
                  end else begin
                     r_mosi <= r_tx[6];
                     r_tx   <= {r_tx[6:0], 1'b0};
                  end
               end else begin
                  r_div_cnt <= r_div_cnt - c_div_one;
               end
            end

            // One extra count on entry keeps the acceptance-to-done latency at 1+16*CLK_DIV.
            S_WAIT: begin
               if (bus.start) begin
                  r_tx      <= bus.din;
                  r_last    <= bus.last;
                  r_mosi    <= bus.din[7];
                  r_busy    <= 1'b1;
                  r_div_cnt <= c_div_full;
                  r_half    <= '0;
                  r_state   <= S_XFER;
               end
            end

            S_TEARDOWN: begin
               if (r_ss_cnt == '0) begin
                  r_ss    <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_ss_cnt <= r_ss_cnt - c_ss_one;
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.mosi = r_mosi;
   assign bus.sck  = r_sck;
   assign bus.ss   = r_ss;
   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.dout = r_dout;
endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master
// Brief    : Directed checks of spi_master at CLK_DIV=4/SS_SETUP=2 and CLK_DIV=1/SS_SETUP=1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   spi_master_if bus_a ();
   spi_master_if bus_b ();

   spi_master #(.CLK_DIV(4), .SS_SETUP(2)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   spi_master #(.CLK_DIV(1), .SS_SETUP(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int t0    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Slave model on A: returns slv_byte MSB first, shifting on sck falling.
   logic       loop_a   = 1'b1;
   logic [7:0] slv_byte = 8'h00;
   logic [7:0] slv_sh   = 8'h00;
   logic [7:0] slv_rx_a = 8'h00;
   logic [7:0] slv_rx_b = 8'h00;
   always @(negedge bus_a.ss) slv_sh = slv_byte;
   always @(negedge bus_a.sck) if (bus_a.ss === 1'b0) slv_sh = {slv_sh[6:0], 1'b0};
   always @(posedge bus_a.sck) slv_rx_a = {slv_rx_a[6:0], bus_a.mosi};
   always @(posedge bus_b.sck) slv_rx_b = {slv_rx_b[6:0], bus_b.mosi};
   assign bus_a.miso = loop_a ? bus_a.mosi : slv_sh[7];
   assign bus_b.miso = bus_b.mosi;

   // Event recorders, sampled on the falling clk edge.
   logic       p_sck_a = 1'b0, p_ss_a = 1'b1, p_mosi_a = 1'b0, p_sck_b = 1'b0, p_ss_b = 1'b1;
   int         rises_a = 0, first_rise_a = 0, dones_a = 0, done_at_a = 0, ss_rise_a = 0;
   int         ss_rises_a = 0, mosi_bad_a = 0;
   int         rises_b = 0, first_rise_b = 0, second_rise_b = 0, dones_b = 0, done_at_b = 0, ss_rise_b = 0;
   logic [7:0] dout_at_a = 8'h00, dout_at_b = 8'h00;

   always @(negedge clk) begin
      if (bus_a.sck === 1'b1 && p_sck_a === 1'b0) begin
         if (rises_a == 0) first_rise_a = cyc;
         rises_a++;
      end
      if (bus_a.ss === 1'b1 && p_ss_a === 1'b0) begin
         ss_rise_a = cyc;
         ss_rises_a++;
      end
      if (bus_a.mosi !== p_mosi_a && bus_a.sck === 1'b1) mosi_bad_a++;
      if (bus_a.done === 1'b1) begin
         dones_a++;
         done_at_a = cyc;
         dout_at_a = bus_a.dout;
      end
      p_sck_a  = bus_a.sck;
      p_ss_a   = bus_a.ss;
      p_mosi_a = bus_a.mosi;
      if (bus_b.sck === 1'b1 && p_sck_b === 1'b0) begin
         if (rises_b == 0) first_rise_b = cyc;
         if (rises_b == 1) second_rise_b = cyc;
         rises_b++;
      end
      if (bus_b.ss === 1'b1 && p_ss_b === 1'b0) ss_rise_b = cyc;
      if (bus_b.done === 1'b1) begin
         dones_b++;
         done_at_b = cyc;
         dout_at_b = bus_b.dout;
      end
      p_sck_b = bus_b.sck;
      p_ss_b  = bus_b.ss;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit sel, input logic s, input logic [7:0] d, input logic l);
      if (sel) begin
         bus_b.start = s; bus_b.din = d; bus_b.last = l;
      end else begin
         bus_a.start = s; bus_a.din = d; bus_a.last = l;
      end
   endtask

   // Start is sampled at edge 0; t0 is taken on the falling edge that follows it.
   task automatic go(input bit sel, input logic [7:0] d, input logic l);
      @(negedge clk);
      drive(sel, 1'b1, d, l);
      @(negedge clk);
      drive(sel, 1'b0, 8'h00, 1'b0);
      t0 = cyc;
   endtask

   task automatic pulse_at(input int rel, input logic [7:0] d, input logic l);
      while (cyc - t0 < rel) @(negedge clk);
      drive(1'b0, 1'b1, d, l);
      @(negedge clk);
      drive(1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   int b_rises, b_dones, b_mosi, b_ssr, n;

   initial begin
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      idle(3);
      chk("rst_ss",   bus_a.ss,   1);
      chk("rst_sck",  bus_a.sck,  0);
      chk("rst_mosi", bus_a.mosi, 0);
      chk("rst_busy", bus_a.busy, 0);
      chk("rst_done", bus_a.done, 0);
      chk("rst_dout", bus_a.dout, 8'h00);
      chk("rst_b_ss", bus_b.ss,   1);
      rst = 1'b0;
      idle(2);

      // 1: loopback 0xA5
      b_mosi = mosi_bad_a;
      go(1'b0, 8'hA5, 1'b1);
      chk("t1_busy_e0", bus_a.busy, 1);
      chk("t1_ss_e0",   bus_a.ss,   1);
      idle(1);
      chk("t1_ss_e1",   bus_a.ss,   0);
      idle(80);
      chk("t1_rises",     rises_a, 8);
      chk("t1_first_rise", first_rise_a - t0, 7);
      chk("t1_dones",     dones_a, 1);
      chk("t1_done_at",   done_at_a - t0, 67);
      chk("t1_dout",      dout_at_a, 8'hA5);
      chk("t1_ss_rise",   ss_rise_a - t0, 69);
      chk("t1_slv_rx",    slv_rx_a, 8'hA5);
      chk("t1_busy_end",  bus_a.busy, 0);
      chk("t1_mosi_hold", mosi_bad_a - b_mosi, 0);

      // 2: independent slave returns 0x3C while sending 0xFF
      loop_a = 1'b0; slv_byte = 8'h3C;
      b_rises = rises_a; b_mosi = mosi_bad_a;
      go(1'b0, 8'hFF, 1'b1);
      idle(80);
      chk("t2_dout",      dout_at_a, 8'h3C);
      chk("t2_slv_rx",    slv_rx_a, 8'hFF);
      chk("t2_rises",     rises_a - b_rises, 8);
      chk("t2_mosi_hold", mosi_bad_a - b_mosi, 0);
      loop_a = 1'b1;

      // 3: burst 0x12 (last=0) then 0x34 (last=1)
      b_rises = rises_a; b_dones = dones_a; b_ssr = ss_rises_a; b_mosi = mosi_bad_a;
      go(1'b0, 8'h12, 1'b0);
      idle(70);
      chk("t3_dout1",  dout_at_a, 8'h12);
      chk("t3_wait_ss", bus_a.ss, 0);
      chk("t3_wait_busy", bus_a.busy, 0);
      chk("t3_wait_sck", bus_a.sck, 0);
      go(1'b0, 8'h34, 1'b1);
      idle(80);
      chk("t3_dones",   dones_a - b_dones, 2);
      chk("t3_done_at", done_at_a - t0, 65);
      chk("t3_dout2",   dout_at_a, 8'h34);
      chk("t3_ss_rises", ss_rises_a - b_ssr, 1);
      chk("t3_rises",   rises_a - b_rises, 16);
      chk("t3_slv_rx",  slv_rx_a, 8'h34);
      chk("t3_mosi_hold", mosi_bad_a - b_mosi, 0);

      // 4: starts during SETUP, XFER, the done cycle and TEARDOWN are ignored
      b_rises = rises_a; b_dones = dones_a;
      go(1'b0, 8'h5A, 1'b1);
      pulse_at(1, 8'hFF, 1'b0);
      pulse_at(20, 8'h00, 1'b0);
      pulse_at(66, 8'hFF, 1'b0);
      pulse_at(68, 8'h00, 1'b0);
      idle(80);
      chk("t4_dones",  dones_a - b_dones, 1);
      chk("t4_dout",   dout_at_a, 8'h5A);
      chk("t4_slv_rx", slv_rx_a, 8'h5A);
      chk("t4_rises",  rises_a - b_rises, 8);
      chk("t4_ss",     bus_a.ss, 1);

      // 5: reset after 3 sck rises
      b_rises = rises_a; b_dones = dones_a;
      go(1'b0, 8'hC3, 1'b1);
      n = 0;
      while (rises_a - b_rises < 3 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("t5_reach_3", (rises_a - b_rises >= 3) ? 1 : 0, 1);
      rst = 1'b1;
      #1;
      chk("t5_rst_ss",   bus_a.ss,   1);
      chk("t5_rst_sck",  bus_a.sck,  0);
      chk("t5_rst_busy", bus_a.busy, 0);
      chk("t5_rst_done", bus_a.done, 0);
      idle(2);
      rst = 1'b0;
      idle(2);
      chk("t5_no_done", dones_a - b_dones, 0);
      b_rises = rises_a;
      go(1'b0, 8'h96, 1'b1);
      idle(80);
      chk("t5_dones", dones_a - b_dones, 1);
      chk("t5_dout",  dout_at_a, 8'h96);
      chk("t5_rises", rises_a - b_rises, 8);

      // 6: CLK_DIV=1, SS_SETUP=1 loopback 0x81
      go(1'b1, 8'h81, 1'b1);
      idle(40);
      chk("t6_dones",      dones_b, 1);
      chk("t6_done_at",    done_at_b - t0, 18);
      chk("t6_dout",       dout_at_b, 8'h81);
      chk("t6_rises",      rises_b, 8);
      chk("t6_first_rise", first_rise_b - t0, 3);
      chk("t6_sck_period", second_rise_b - first_rise_b, 2);
      chk("t6_ss_rise",    ss_rise_b - t0, 19);
      chk("t6_slv_rx",     slv_rx_b, 8'h81);
      chk("t6_busy_end",   bus_b.busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
